// File: rtl/ooo_resp_pkg.sv
// Shared types and sizes for the out-of-order read responder.
package ooo_resp_pkg;

  localparam int unsigned ID_W      = 4;
  localparam int unsigned NUM_SLOTS = 16;
  localparam int unsigned CNT_W     = 5;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    READY,
    ISSUED
  } slot_state_e;

endpackage

// File: rtl/ooo_resp_slot.sv
// One per-ID request slot: holds the address and counts down the response latency.
module ooo_resp_slot
  import ooo_resp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [CNT_W-1:0]      load_cnt,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic                  grant,
  input  logic                  done,
  output slot_state_e           o_state,
  output logic                  o_ready,
  output logic [ADDR_WIDTH-1:0] o_addr
);

  slot_state_e           r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (load) begin
            r_addr  <= load_addr;
            r_cnt   <= load_cnt;
            r_state <= (load_cnt == '0) ? READY : WAIT;
          end
        end
        WAIT: begin
          // cnt is never 0 here, so the 1->0 step is the last WAIT cycle
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) r_state <= READY;
        end
        READY: begin
          if (grant) r_state <= ISSUED;
        end
        ISSUED: begin
          if (done) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_state = r_state;
  assign o_ready = (r_state == READY);
  assign o_addr  = r_addr;

endmodule

// File: rtl/ooo_read_responder.sv
// AR/R read responder: per-ID latency slots, fixed-priority arbiter, registered R output.
module ooo_read_responder
  import ooo_resp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned LAT_MIN    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_W-1:0]       s_arid_i,
  input  logic [ADDR_WIDTH-1:0] s_araddr_i,
  input  logic                  s_arvalid_i,
  output logic                  s_arready_o,
  output logic [DATA_WIDTH-1:0] s_rdata_o,
  output logic [ID_W-1:0]       s_rid_o,
  output logic                  s_rvalid_o,
  input  logic                  s_rready_i
);

  slot_state_e           w_state [NUM_SLOTS];
  logic [ADDR_WIDTH-1:0] w_addr  [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]  w_ready;
  logic [NUM_SLOTS-1:0]  w_load;
  logic [NUM_SLOTS-1:0]  w_grant;
  logic [NUM_SLOTS-1:0]  w_done;
  logic [CNT_W-1:0]      w_load_cnt;
  logic                  w_ar_hs;
  logic                  w_r_hs;
  logic                  w_r_load;
  logic                  w_any;
  logic [ID_W-1:0]       w_win;

  logic                  r_rvalid;
  logic [ID_W-1:0]       r_rid;
  logic [DATA_WIDTH-1:0] r_rdata;

  assign s_arready_o = !rst && (w_state[s_arid_i] == IDLE);
  assign w_ar_hs     = s_arvalid_i && s_arready_o;
  assign w_r_hs      = r_rvalid && s_rready_i;
  assign w_r_load    = !r_rvalid || w_r_hs;
  assign w_load_cnt  = CNT_W'(LAT_MIN) + CNT_W'(s_araddr_i[1:0]);

  // Scan high to low so the lowest-index READY slot ends up as the winner
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
      if (w_ready[i]) begin
        w_any = 1'b1;
        w_win = ID_W'(i);
      end
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    assign w_load[g]  = w_ar_hs && (s_arid_i == ID_W'(g));
    assign w_grant[g] = w_r_load && w_any && (w_win == ID_W'(g));
    assign w_done[g]  = w_r_hs && (r_rid == ID_W'(g));

    ooo_resp_slot #(
      .ADDR_WIDTH(ADDR_WIDTH)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .load     (w_load[g]),
      .load_cnt (w_load_cnt),
      .load_addr(s_araddr_i),
      .grant    (w_grant[g]),
      .done     (w_done[g]),
      .o_state  (w_state[g]),
      .o_ready  (w_ready[g]),
      .o_addr   (w_addr[g])
    );
  end

  // rid/rdata only change when the register is empty or its beat is being taken
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rvalid <= 1'b0;
      r_rid    <= '0;
      r_rdata  <= '0;
    end else if (w_r_load) begin
      r_rvalid <= w_any;
      if (w_any) begin
        r_rid   <= w_win;
        r_rdata <= DATA_WIDTH'(w_addr[w_win]);
      end
    end
  end

  assign s_rvalid_o = r_rvalid;
  assign s_rid_o    = r_rid;
  assign s_rdata_o  = r_rdata;

endmodule

// File: doc/ooo_read_responder.md
# ooo_read_responder

Out-of-order AXI-style read responder: the downstream end of the AR/R read channel whose upstream side is our reorder buffer. Accepts AR requests tagged with a 4-bit ID and returns R beats after an address-dependent latency. Responses complete out of order across IDs. Used as the bench and system-level memory model behind the reorder buffer, and as the stimulus source for exercising its reordering.

## Interface

- DATA_WIDTH, 8, R data width
- ADDR_WIDTH, 8, AR address width (≥2)
- LAT_MIN, 2, base response latency in cycles (0..28)

Ports:

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- s_arid_i  in  4  request ID
- s_araddr_i  in  ADDR_WIDTH  request address
- s_arvalid_i  in  1  AR valid
- s_arready_o  out  1  AR ready
- s_rdata_o  out  DATA_WIDTH  response data
- s_rid_o  out  4  response ID
- s_rvalid_o  out  1  R valid
- s_rready_i  in  1  R ready

## Operation

- 16 slots, one per ID, indexed directly by ID. Each slot holds state, 5-bit countdown and the stored address.
- Slot FSM states:
  - IDLE → WAIT on AR handshake with cnt = LAT_MIN + araddr[1:0]; if that value is 0, the slot goes straight to READY.
  - WAIT: cnt decrements every cycle; → READY on the edge where cnt goes 1→0.
  - READY → ISSUED when the arbiter selects the slot.
  - ISSUED → IDLE on R handshake for that ID.
- s_arready_o = !rst && slot[s_arid_i] is IDLE. This is combinational on s_arid_i. At most one outstanding request per ID.
- AR handshake = s_arvalid_i && s_arready_o.
- R output register holds rvalid/rid/rdata and loads when empty or when a handshake occurs this cycle.
- Arbiter is fixed priority: lowest-index READY slot wins. rdata = stored address zero-extended or truncated to DATA_WIDTH.
- Once rvalid is high, rid and rdata stay stable until s_rready_i. rvalid never drops without a handshake, except on reset.
- Same ID on AR and R handshake in the same cycle: AR is not accepted, because the slot is still ISSUED. It is accepted the following cycle.
- An AR for ID k and an R handshake for ID j≠k in the same cycle are both performed.
- Back-to-back R: on a handshake, the next READY slot loads in the same cycle, giving 1 beat/cycle throughput.

## Timing

- With AR handshake in cycle t, L = LAT_MIN + araddr[1:0], and no contention, s_rvalid_o is first high in cycle t+2+L.
- A contended READY slot waits one cycle per higher-priority winner plus any backpressure cycles.
- Reset values: s_rvalid_o=0, s_rid_o=0, s_rdata_o=0, all slots IDLE, s_arready_o=0 while rst is high.
- In the first cycle after reset deasserts, s_arready_o=1 for any ID.
- Reset mid-operation drops all pending and issued requests. rvalid is 0 in the cycle after the reset edge. No stale response is ever emitted.
- Countdown arithmetic is 5-bit unsigned with no wrap: LAT_MIN+3 ≤ 31, guaranteed by the LAT_MIN range.

## Structure

- Package ooo_resp_pkg holds:
  - ID_W=4, NUM_SLOTS=16, CNT_W=5
  - slot_state_e enum {IDLE, WAIT, READY, ISSUED}
- Sub-module ooo_resp_slot is instantiated 16 times. Ports: clk, rst, load, load_cnt, load_addr, grant, done. It outputs state/ready and the stored address.
- Top level contains the AR decode, fixed-priority arbiter and R output register.

## Test plan

- **Out-of-order return.** LAT_MIN=2, rready=1. AR id=3 addr=0x03 in cycle 0, then AR id=5 addr=0x00 in cycle 1 → R id=5 rdata=0x00 in cycle 5, then R id=3 rdata=0x03 in cycle 7.
- **Arbitration.** AR id=9 addr=0x00 in cycle 0 and AR id=2 addr=0x00 in cycle 0+… arranged so both slots become READY in the same cycle → id=2 is returned first, id=9 in the next cycle.
- **Backpressure.** rready held 0 for 10 cycles while rvalid=1 for id=7 → rid=7 and rdata stay constant, no other beat appears, and the beat completes on the first cycle rready=1.
- **Duplicate ID.** id=4 outstanding, AR id=4 presented → arready=0 through the cycle of the R handshake for id=4, and arready=1 in the next cycle.
- **Full occupancy.** AR for all IDs 0..15 with random addresses → every ID is returned exactly once with the correct data, and arready=0 for every ID until its own response completes.
- **Reset mid-operation.** rst pulsed for 1 cycle with 6 requests pending → rvalid=0 after reset, no responses for those 6 IDs ever appear, and a new AR for id=0 returns normally at t+2+L.
